// File: rtl/gpu_ram_pkg.sv
// rtl/gpu_ram_pkg.sv - shared constants and helpers for the GPU RAM host port
package gpu_ram_pkg;

    localparam int GPU_ADDR_W    = 20;
    localparam int HOST_DATA_W   = 8;
    localparam int DEF_ADDR_SIZE = 14;
    localparam int DEF_RAM_LAT   = 2;

    localparam logic [HOST_DATA_W-1:0] OOR_READ_DATA = 8'hFF;

    // Width of a requester index; a single requester still gets one bit
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_rr_select.sv
// rtl/gpu_rr_select.sv - combinational round-robin winner picker
module gpu_rr_select
    import gpu_ram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    // Scan from the requester after the last grant, wrapping, and take the first eligible one
    always_comb begin
        int          idx;
        logic [IDX_W-1:0] pos;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        pos    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            pos = IDX_W'(idx);
            if (!found && eligible[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

endmodule

// File: rtl/gpu_host_port_arbiter.sv
// rtl/gpu_host_port_arbiter.sv - round-robin arbiter sharing GPU RAM port B among host requesters
module gpu_host_port_arbiter
    import gpu_ram_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int RAM_LAT   = DEF_RAM_LAT
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*GPU_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*HOST_DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [HOST_DATA_W-1:0]          rd_data,
    output logic [GPU_ADDR_W-1:0]           ram_addr,
    output logic                            ram_wr_en,
    output logic [HOST_DATA_W-1:0]          ram_wdata,
    input  logic [HOST_DATA_W-1:0]          ram_rdata,
    output logic                            oor_pulse
);

    localparam int IDX_W = idx_bits(NUM_REQ);
    localparam int LAST  = RAM_LAT - 1;

    logic [NUM_REQ-1:0]     eligible;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       win_id;
    logic                   win_found;

    logic [GPU_ADDR_W-1:0]  sel_addr;
    logic                   sel_wr;
    logic [HOST_DATA_W-1:0] sel_wdata;
    logic                   sel_oor;

    // Attributes of the access presented to the RAM this cycle
    logic [IDX_W-1:0]       gnt_id;
    logic                   gnt_rd;
    logic                   gnt_oor;

    // Read-return tracking: stage k describes the read acked k+1 cycles ago
    logic                   pipe_vld [RAM_LAT];
    logic [IDX_W-1:0]       pipe_id  [RAM_LAT];
    logic                   pipe_oor [RAM_LAT];

    // A requester seeing its ack this cycle is still holding req, so it sits this round out
    assign eligible = req & ~ack;

    gpu_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .eligible   (eligible),
        .last_grant (last_grant),
        .winner     (win_id),
        .found      (win_found)
    );

    // Route the winner's command fields and flag addresses beyond the implemented RAM
    always_comb begin
        sel_addr  = req_addr[int'(win_id)*GPU_ADDR_W +: GPU_ADDR_W];
        sel_wdata = req_wdata[int'(win_id)*HOST_DATA_W +: HOST_DATA_W];
        sel_wr    = req_wr[win_id];
        sel_oor   = (sel_addr >> ADDR_SIZE) != '0;
    end

    // Register the grant: drive port B, pulse ack, advance round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack        <= '0;
            ram_wr_en  <= 1'b0;
            oor_pulse  <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt_id     <= '0;
            gnt_rd     <= 1'b0;
            gnt_oor    <= 1'b0;
        end else begin
            ack       <= win_found ? (NUM_REQ'(1) << win_id) : '0;
            ram_wr_en <= win_found & sel_wr & ~sel_oor;
            oor_pulse <= win_found & sel_oor;
            gnt_rd    <= win_found & ~sel_wr;
            gnt_id    <= win_id;
            gnt_oor   <= sel_oor;
            if (win_found) begin
                ram_addr   <= sel_addr;
                ram_wdata  <= sel_wdata;
                last_grant <= win_id;
            end
        end
    end

    // Shift read ownership along until the RAM data is due
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < RAM_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_id[k]  <= '0;
                pipe_oor[k] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= gnt_rd;
            pipe_id[0]  <= gnt_id;
            pipe_oor[0] <= gnt_oor;
            for (int k = 1; k < RAM_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
                pipe_oor[k] <= pipe_oor[k-1];
            end
        end
    end

    // Capture the returning byte and pulse rd_valid to its owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pipe_vld[LAST] ? (NUM_REQ'(1) << pipe_id[LAST]) : '0;
            if (pipe_vld[LAST]) begin
                rd_data <= pipe_oor[LAST] ? OOR_READ_DATA : ram_rdata;
            end
        end
    end

endmodule
